operand_issue: RTL



---
 rtl/operand_issue_if.sv | 30 +++
 rtl/operand_issue.sv | 74 +++++++
 2 files changed

// File: rtl/operand_issue_if.sv
// Operand-issue slot bundle: decoded-instruction input side and ALU-facing output side.
// master drives the instruction/flush/out_ready; slave (operand_issue) drives the slot outputs.
interface operand_issue_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [DATA_WIDTH-1:0] imm;
    logic                  ALUsrc;
    logic [2:0]            ALUCtrl_in;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] ALUop1;
    logic [DATA_WIDTH-1:0] ALUop2;
    logic [2:0]            ALUCtrl;

    modport master (
        output in_valid, rs1, rs2, imm, ALUsrc, ALUCtrl_in, flush, out_ready,
        input  in_ready, out_valid, ALUop1, ALUop2, ALUCtrl
    );

    modport slave (
        input  in_valid, rs1, rs2, imm, ALUsrc, ALUCtrl_in, flush, out_ready,
        output in_ready, out_valid, ALUop1, ALUop2, ALUCtrl
    );
endinterface

// File: rtl/operand_issue.sv
// Operand-issue stage: register file, operand select and a one-slot valid/ready pipeline register.
// Define OPERAND_BYPASS_EN to forward a same-cycle write-back into the captured operands.
module operand_issue #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    operand_issue_if.slave        bus,
    input  logic                  we3_i,
    input  logic [ADDR_WIDTH-1:0] ad3_i,
    input  logic [DATA_WIDTH-1:0] wd3_i,
    output logic [DATA_WIDTH-1:0] a0_o
);
    localparam int unsigned NumRegs = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] A0Idx = ADDR_WIDTH'(10);

    logic [DATA_WIDTH-1:0] rf_q [NumRegs];
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] op1_q, op2_q, a0_q;
    logic [DATA_WIDTH-1:0] rd1, rd2, op2_d;
    logic [2:0]            ctrl_q;
    logic                  wr_en, capture;

    assign wr_en   = we3_i && (ad3_i != '0);
    assign capture = bus.in_valid && bus.in_ready && !bus.flush;

    always_comb begin
        rd1 = (bus.rs1 == '0) ? '0 : rf_q[bus.rs1];
        rd2 = (bus.rs2 == '0) ? '0 : rf_q[bus.rs2];
`ifdef OPERAND_BYPASS_EN
        if (wr_en && (ad3_i == bus.rs1)) rd1 = wd3_i;
        if (wr_en && (ad3_i == bus.rs2)) rd2 = wd3_i;
`else
        // Captures see the pre-write value; upstream inserts a bubble after a write.
`endif
        op2_d = bus.ALUsrc ? bus.imm : rd2;
    end

    // Flush wins over a simultaneous capture and also empties a held slot.
    always_comb begin
        valid_d = valid_q;
        if (bus.flush)          valid_d = 1'b0;
        else if (capture)       valid_d = 1'b1;
        else if (bus.out_ready) valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NumRegs); i++) rf_q[i] <= '0;
            valid_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            ctrl_q  <= 3'b000;
            a0_q    <= '0;
        end else begin
            if (wr_en) rf_q[ad3_i] <= wd3_i;
            valid_q <= valid_d;
            if (capture) begin
                op1_q  <= rd1;
                op2_q  <= op2_d;
                ctrl_q <= bus.ALUCtrl_in;
            end
            a0_q <= (wr_en && (ad3_i == A0Idx)) ? wd3_i : rf_q[A0Idx];
        end
    end

    assign bus.in_ready  = !valid_q || bus.out_ready;
    assign bus.out_valid = valid_q;
    assign bus.ALUop1    = op1_q;
    assign bus.ALUop2    = op2_q;
    assign bus.ALUCtrl   = ctrl_q;
    assign a0_o          = a0_q;
endmodule
